// File: rtl/csrng_upd_arb.sv
// csrng_upd_arb: round-robin arbiter sharing one ctr_drbg update unit between NumReq requesters.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   enable_i                           block enable, low clears state synchronously
//   req_vld_i/req_rdy_o/req_data_i     requester side request handshake and packed data
//   upd_req_o/upd_rdy_i/upd_data_o     update unit request handshake and granted data
//   upd_ack_i/upd_rdy_o/upd_rsp_i      update unit response handshake and data
//   rsp_ack_o/rsp_rdy_i/rsp_data_o     requester side response handshake and data
//   err_o                              {push while full, pop while empty, ack with no owner}
module csrng_upd_arb #(
   parameter int NumReq   = 2,
   parameter int Cmd      = 3,
   parameter int StateId  = 4,
   parameter int KeyLen   = 256,
   parameter int BlkLen   = 128,
   parameter int SeedLen  = 384,
   parameter int TagDepth = 2,
   localparam int ReqW = Cmd + StateId + SeedLen + KeyLen + BlkLen,
   localparam int RspW = Cmd + StateId + KeyLen + BlkLen
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   enable_i,
   input  logic [NumReq-1:0]      req_vld_i,
   output logic [NumReq-1:0]      req_rdy_o,
   input  logic [NumReq*ReqW-1:0] req_data_i,
   output logic                   upd_req_o,
   input  logic                   upd_rdy_i,
   output logic [ReqW-1:0]        upd_data_o,
   input  logic                   upd_ack_i,
   output logic                   upd_rdy_o,
   input  logic [RspW-1:0]        upd_rsp_i,
   output logic [NumReq-1:0]      rsp_ack_o,
   input  logic [NumReq-1:0]      rsp_rdy_i,
   output logic [RspW-1:0]        rsp_data_o,
   output logic [2:0]             err_o
);
   localparam int IdxW = NumReq > 1 ? $clog2(NumReq) : 1;
   localparam int PtrW = TagDepth > 1 ? $clog2(TagDepth) : 1;
   localparam int CntW = $clog2(TagDepth + 1);
   typedef enum logic {Idle, Lock} state_e;
   state_e          state_q, state_d;
   logic [IdxW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, pick, j, head;
   logic [IdxW-1:0] tag_q [TagDepth];
   logic [PtrW-1:0] rd_q, wr_q;
   logic [CntW-1:0] cnt_q;
   logic            full, empty, push, pop, gnt_ok;
   function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(TagDepth - 1)) ? '0 : p + 1'b1;
   endfunction
   assign full   = cnt_q == CntW'(TagDepth);
   assign empty  = cnt_q == '0;
   assign head   = tag_q[rd_q];
   // A non-power-of-2 NumReq leaves unused grant codes; treat them as no request.
   assign gnt_ok = int'(gnt_q) < NumReq;
   // First valid requester at or after ptr, wrapping; scanning backwards lets the nearest win.
   always_comb begin
      pick = ptr_q;
      j    = '0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         j = IdxW'((int'(ptr_q) + k) % NumReq);
         if (req_vld_i[j]) pick = j;
      end
   end
   assign upd_req_o  = enable_i && state_q == Lock && gnt_ok;
   assign upd_data_o = upd_req_o ? req_data_i[int'(gnt_q)*ReqW +: ReqW] : '0;
   assign push       = upd_req_o && upd_rdy_i;
   assign req_rdy_o  = NumReq'(push) << gnt_q;
   assign upd_rdy_o  = enable_i && !empty && rsp_rdy_i[head];
   assign pop        = upd_ack_i && upd_rdy_o;
   assign rsp_ack_o  = NumReq'(pop) << head;
   assign rsp_data_o = (enable_i && !empty) ? upd_rsp_i : '0;
   assign err_o      = {push && full && !pop, pop && empty, enable_i && upd_ack_i && empty};
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      if (!enable_i) begin
         state_d = Idle;
         gnt_d   = '0;
         ptr_d   = '0;
      end else if (state_q == Idle) begin
         // A same-cycle pop frees a slot, so a full FIFO does not block that grant.
         if (|req_vld_i && (!full || pop)) begin
            state_d = Lock;
            gnt_d   = pick;
         end
      end else if (!gnt_ok) begin
         state_d = Idle;
      end else if (upd_rdy_i) begin
         state_d = Idle;
         ptr_d   = IdxW'((int'(gnt_q) + 1) % NumReq);
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Idle;
         gnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < TagDepth; i++) tag_q[i] <= '0;
      end else if (!enable_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            tag_q[wr_q] <= gnt_q;
            wr_q        <= wrap_inc(wr_q);
         end
         if (pop) rd_q <= wrap_inc(rd_q);
         cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
      end
   end
endmodule
